// File: rtl/quadrature_encoder_gen.sv
// Quadrature A/B waveform generator driven by step commands.
// Emits Gray-code edges at a programmed spacing and tracks emitted position.
module quadrature_encoder_gen #(
  parameter int CNT_W  = 8,
  parameter int STEP_W = 16,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0]  cmd_period,
  input  logic              abort,
  output logic              A_channel,
  output logic              B_channel,
  output logic [CNT_W-1:0]  position,
  output logic              busy,
  output logic              done
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  localparam logic [DIV_W-1:0]  ONE_D = DIV_W'(1);
  localparam logic [STEP_W-1:0] ONE_S = STEP_W'(1);

  state_t            r_state;
  logic              r_a;
  logic              r_b;
  logic              r_dir;
  logic              r_done;
  logic [CNT_W-1:0]  r_pos;
  logic [STEP_W-1:0] r_rem;
  logic [DIV_W-1:0]  r_timer;
  logic [DIV_W-1:0]  r_period;

  logic              w_acc;
  logic              w_dir;
  logic              w_tog_a;
  logic              w_na;
  logic              w_nb;
  logic [DIV_W-1:0]  w_per;
  logic [CNT_W-1:0]  w_npos;

  assign w_acc   = cmd_valid && (r_state == S_IDLE);
  assign w_per   = (cmd_period == '0) ? ONE_D : cmd_period;
  assign w_dir   = w_acc ? cmd_dir : r_dir;
  // Forward toggles A when A==B, so new A always differs from old B.
  assign w_tog_a = ~(w_dir ^ (r_a == r_b));
  assign w_na    = r_a ^ w_tog_a;
  assign w_nb    = r_b ^ ~w_tog_a;
  assign w_npos  = w_dir ? r_pos + 1'b1 : r_pos - 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= 1'b0;
      r_b      <= 1'b0;
      r_dir    <= 1'b0;
      r_done   <= 1'b0;
      r_pos    <= '0;
      r_rem    <= '0;
      r_timer  <= '0;
      r_period <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_dir    <= cmd_dir;
            r_period <= w_per;
            if (cmd_steps == '0) begin
              r_done <= 1'b1;
            end else if (w_per == ONE_D) begin
              // Accept cycle counts as the first period tick.
              r_a     <= w_na;
              r_b     <= w_nb;
              r_pos   <= w_npos;
              r_rem   <= cmd_steps - ONE_S;
              r_timer <= ONE_D;
              if (cmd_steps == ONE_S) r_done  <= 1'b1;
              else                    r_state <= S_RUN;
            end else begin
              r_rem   <= cmd_steps;
              r_timer <= w_per - ONE_D;
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else if (r_timer == ONE_D) begin
            r_a     <= w_na;
            r_b     <= w_nb;
            r_pos   <= w_npos;
            r_rem   <= r_rem - ONE_S;
            r_timer <= r_period;
            if (r_rem == ONE_S) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end else begin
            r_timer <= r_timer - ONE_D;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state == S_RUN);
  assign done      = r_done;
  assign A_channel = r_a;
  assign B_channel = r_b;
  assign position  = r_pos;

endmodule
